// File: rtl/fetch_queue_if.sv
// IF-to-ID fetch queue bundle: fetch side, flush/stall controls, decode side, PC enable and occupancy.
interface fetch_queue_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_instr;
  logic          flush;
  logic          id_stall;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc_plus4;
  logic          hazDetect_PC;
  logic [CW-1:0] fq_count;

  modport master (
    output if_valid, if_pc, if_instr, flush, id_stall,
    input  id_valid, id_pc, id_instr, id_pc_plus4, hazDetect_PC, fq_count
  );

  modport slave (
    input  if_valid, if_pc, if_instr, flush, id_stall,
    output id_valid, id_pc, id_instr, id_pc_plus4, hazDetect_PC, fq_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular IF/ID fetch queue: 1-cycle push-to-decode latency (0 with FETCH_QUEUE_BYPASS_EN),
// holds the PC via hazDetect_PC while full; flush/reset drop all queued instructions.
module fetch_queue #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic      clk,
  input  logic      reset,
  fetch_queue_if.slave fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            head_vld;
  entry_t          head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && !fq.id_stall;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass   = empty && fq.if_valid && !fq.flush;
  // A bypassed instruction taken by decode this cycle must not also be queued.
  assign push     = fq.if_valid && !full && !fq.flush && !(bypass && !fq.id_stall);
  assign head_vld = !empty || bypass;
  assign head     = empty ? {fq.if_pc, fq.if_instr} : mem[rd_ptr];
`else
  assign push     = fq.if_valid && !full && !fq.flush;
  assign head_vld = !empty;
  assign head     = mem[rd_ptr];
`endif

  assign fq.id_valid     = head_vld;
  assign fq.id_pc        = head_vld ? head.pc : 32'h0;
  assign fq.id_instr     = head_vld ? head.instr : NOP;
  assign fq.id_pc_plus4  = fq.id_pc + 32'd4;
  // Forced high in reset so the PC's own synchronous reset can take effect.
  assign fq.hazDetect_PC = !full || fq.flush || reset;
  assign fq.fq_count     = count;

  always_ff @(posedge clk) begin
    if (reset || fq.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Payload storage is never cleared; validity lives entirely in count.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= {fq.if_pc, fq.if_instr};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=2, default build without bypass).
module tb_fetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  fetch_queue_if #(.DEPTH(2)) fq ();
  fetch_queue #(.DEPTH(2), .NOP(NOP)) dut (.clk(clk), .reset(reset), .fq(fq));

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return 32'hC000_0000 | pc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic fl, input logic st);
    fq.if_valid = v;
    fq.if_pc    = pc;
    fq.if_instr = mk(pc);
    fq.flush    = fl;
    fq.id_stall = st;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tb_pc;
  logic [31:0] exp_pc;
  logic        st;
  int          budget;

  initial begin
    // 1. reset held two cycles with a fetch present
    drv(1'b1, 32'h100, 1'b0, 1'b0);
    chk("rst_haz_t0", {31'b0, fq.hazDetect_PC}, 32'd1);
    cyc();
    chk("rst_valid", {31'b0, fq.id_valid}, 32'd0);
    chk("rst_instr", fq.id_instr, NOP);
    chk("rst_pc", fq.id_pc, 32'h0);
    chk("rst_pc4", fq.id_pc_plus4, 32'h4);
    chk("rst_cnt", 32'(fq.fq_count), 32'd0);
    chk("rst_haz", {31'b0, fq.hazDetect_PC}, 32'd1);
    cyc();
    chk("rst_valid2", {31'b0, fq.id_valid}, 32'd0);
    chk("rst_haz2", {31'b0, fq.hazDetect_PC}, 32'd1);

    // 2. streaming 0x0, 0x4, 0x8
    reset = 1'b0;
    drv(1'b1, 32'h0, 1'b0, 1'b0);
    chk("str_lat", {31'b0, fq.id_valid}, 32'd0);
    cyc();
    drv(1'b1, 32'h4, 1'b0, 1'b0);
    chk("str_v0", {31'b0, fq.id_valid}, 32'd1);
    chk("str_pc0", fq.id_pc, 32'h0);
    chk("str_in0", fq.id_instr, 32'hC000_0000);
    chk("str_p40", fq.id_pc_plus4, 32'h4);
    cyc();
    drv(1'b1, 32'h8, 1'b0, 1'b0);
    chk("str_pc1", fq.id_pc, 32'h4);
    chk("str_cnt1", 32'(fq.fq_count), 32'd1);
    cyc();
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    chk("str_pc2", fq.id_pc, 32'h8);
    chk("str_p42", fq.id_pc_plus4, 32'hC);
    cyc();
    chk("str_empty", {31'b0, fq.id_valid}, 32'd0);
    chk("str_nop", fq.id_instr, NOP);

    // 3. fill while decode stalls
    drv(1'b1, 32'h10, 1'b0, 1'b1);
    chk("fill_haz0", {31'b0, fq.hazDetect_PC}, 32'd1);
    cyc();
    drv(1'b1, 32'h14, 1'b0, 1'b1);
    chk("fill_cnt1", 32'(fq.fq_count), 32'd1);
    cyc();
    drv(1'b1, 32'h18, 1'b0, 1'b1);
    chk("fill_cnt2", 32'(fq.fq_count), 32'd2);
    chk("fill_haz", {31'b0, fq.hazDetect_PC}, 32'd0);
    cyc();
    chk("fill_refuse", 32'(fq.fq_count), 32'd2);
    chk("fill_head", fq.id_pc, 32'h10);
    drv(1'b1, 32'h18, 1'b0, 1'b0);
    chk("fill_haz_nostall", {31'b0, fq.hazDetect_PC}, 32'd0);
    cyc();
    chk("drain_pc10_gone", fq.id_pc, 32'h14);
    chk("drain_cnt", 32'(fq.fq_count), 32'd1);
    chk("drain_haz", {31'b0, fq.hazDetect_PC}, 32'd1);
    cyc();
    drv(1'b0, 32'h1C, 1'b0, 1'b0);
    chk("drain_pc18", fq.id_pc, 32'h18);
    chk("drain_in18", fq.id_instr, 32'hC000_0018);
    cyc();
    chk("drain_empty", 32'(fq.fq_count), 32'd0);

    // 4. flush with a full queue
    drv(1'b1, 32'h20, 1'b0, 1'b1);
    cyc();
    drv(1'b1, 32'h24, 1'b0, 1'b1);
    cyc();
    drv(1'b1, 32'h28, 1'b1, 1'b1);
    chk("fl_haz", {31'b0, fq.hazDetect_PC}, 32'd1);
    chk("fl_cnt_pre", 32'(fq.fq_count), 32'd2);
    cyc();
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    chk("fl_valid", {31'b0, fq.id_valid}, 32'd0);
    chk("fl_cnt", 32'(fq.fq_count), 32'd0);
    chk("fl_haz_post", {31'b0, fq.hazDetect_PC}, 32'd1);
    chk("fl_nop", fq.id_instr, NOP);
    cyc();
    chk("fl_no28", {31'b0, fq.id_valid}, 32'd0);

    // 5. ten instructions from 0x40 with alternating stall; bench acts as the PC
    tb_pc  = 32'h40;
    exp_pc = 32'h40;
    budget = 0;
    while (exp_pc != 32'h68 && budget < 80) begin
      st = budget[0];
      drv(tb_pc != 32'h68, tb_pc, 1'b0, st);
      chk("wrap_cnt_le", {31'b0, (32'(fq.fq_count) <= 2)}, 32'd1);
      if (fq.id_valid && !st) begin
        chk("wrap_order", fq.id_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (fq.hazDetect_PC && tb_pc != 32'h68) tb_pc = tb_pc + 32'd4;
      cyc();
      budget++;
    end
    chk("wrap_done", exp_pc, 32'h68);

    // 6. reset pulse while full
    drv(1'b1, 32'h80, 1'b0, 1'b1);
    cyc();
    drv(1'b1, 32'h84, 1'b0, 1'b1);
    cyc();
    chk("mr_full", 32'(fq.fq_count), 32'd2);
    reset = 1'b1;
    drv(1'b1, 32'h88, 1'b0, 1'b1);
    chk("mr_haz_in_rst", {31'b0, fq.hazDetect_PC}, 32'd1);
    cyc();
    reset = 1'b0;
    drv(1'b1, 32'h0, 1'b0, 1'b0);
    chk("mr_valid", {31'b0, fq.id_valid}, 32'd0);
    chk("mr_cnt", 32'(fq.fq_count), 32'd0);
    chk("mr_instr", fq.id_instr, NOP);
    chk("mr_pc", fq.id_pc, 32'h0);
    chk("mr_pc4", fq.id_pc_plus4, 32'h4);
    chk("mr_haz", {31'b0, fq.hazDetect_PC}, 32'd1);
    cyc();
    drv(1'b0, 32'h4, 1'b0, 1'b0);
    chk("mr_first_v", {31'b0, fq.id_valid}, 32'd1);
    chk("mr_first_pc", fq.id_pc, 32'h0);
    chk("mr_first_in", fq.id_instr, 32'hC000_0000);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Two-entry (parameterisable) instruction fetch queue between the PC register / instruction memory (IF) and the decode stage (ID). It replaces a plain IF/ID register and absorbs decode stalls without losing fetched instructions. It drives the PC write-enable (`hazDetect_PC`) so the PC holds while the queue is full. It discards all in-flight instructions on a branch/jump flush.

## Interface

Parameters:
- `DEPTH`, default 2: number of entries; power of two, 2..8.
- `NOP`, default 32'h00000013: `addi x0,x0,0`, driven on `id_instr` when no instruction is valid.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `if_valid`, input, 1: `if_pc`/`if_instr` carry a fetched instruction this cycle.
- `if_pc`, input, 32: address of the fetched instruction.
- `if_instr`, input, 32: fetched instruction word.
- `flush`, input, 1: taken branch/jump resolved; discard queue contents and the current fetch.
- `id_stall`, input, 1: decode cannot accept (load-use hazard).
- `id_valid`, output, 1: head instruction valid.
- `id_pc`, output, 32: head PC.
- `id_instr`, output, 32: head instruction; `NOP` when `id_valid`=0.
- `id_pc_plus4`, output, 32: `id_pc + 4`, mod 2^32.
- `hazDetect_PC`, output, 1: PC write enable; 1 = PC may load a new value.
- `fq_count`, output, $clog2(DEPTH)+1: occupancy.

## Operation

- push = `if_valid` & !full & !`flush`.
- pop = `id_valid` & !`id_stall`.
- Storage is a circular buffer with read and write pointers of $clog2(DEPTH) bits.
  - Both pointers wrap modulo DEPTH.
  - count increments on push only, decrements on pop only, and is unchanged on push+pop.
- Head entry drives `id_pc`/`id_instr`. `id_valid` = (count != 0).
- Full (count == DEPTH): push is refused even if pop occurs in the same cycle. The instruction is not lost, because the PC was held.
- `hazDetect_PC` = !full | `flush` | `reset`.
  - Combinational from the count register and the `flush`/`reset` inputs only.
  - There is no path from `id_stall`.
  - It is forced high during `reset` because the PC's own reset only takes effect when its enable is high.
- Flush: next cycle count=0, both pointers=0, `id_valid`=0. The same-cycle fetch is dropped and `hazDetect_PC`=1, so the PC loads the target.
- Priority: `reset` > `flush` > push/pop.
- Stored data is not cleared by reset or flush. Only the pointers and count reset.

## Timing

- Reset values: count=0, pointers=0, `id_valid`=0, `id_instr`=`NOP`, `id_pc`=0, `id_pc_plus4`=4, `hazDetect_PC`=1.
- Latency from push to `id_valid` is 1 cycle without bypass (registered IF/ID behaviour) and 0 cycles with bypass (see Configuration).
- Sustained throughput is one instruction per cycle when `id_stall`=0.
- `hazDetect_PC` falls in the cycle after the push that fills the queue. It rises in the cycle after the pop from full.
- Reset asserted mid-operation: all queued instructions are lost. Outputs equal reset values in the cycle after the sampling edge.

## Configuration

- `FETCH_QUEUE_BYPASS_EN` defined:
  - When count==0 and `if_valid` & !`flush`, the `id_*` outputs are driven combinationally from `if_*` with `id_valid`=1.
  - If `id_stall`=0 that instruction is consumed and not written to the queue.
  - If `id_stall`=1 it is pushed normally.
- `FETCH_QUEUE_BYPASS_EN` undefined: no combinational IF-to-ID path. Outputs come only from registered state.

## Test plan

1. Reset: hold `reset` 2 cycles with `if_valid`=1 -> `id_valid`=0, `id_instr`=0x00000013, `hazDetect_PC`=1 throughout, `fq_count`=0.
2. Streaming: PCs 0x0, 0x4, 0x8 with `id_stall`=0 -> ID sees the same PCs in order, one per cycle, at 1-cycle latency (0 with bypass), and `id_pc_plus4` = PC+4.
3. Fill: `id_stall`=1 while pushing 0x10, 0x14, 0x18 -> `fq_count`=2, `hazDetect_PC`=0, and 0x18 is not accepted. Release the stall -> 0x10, then 0x14, then the PC-refetched 0x18, with no loss or duplication.
4. Flush: queue holds 0x20, 0x24 and `flush`=1 with `if_pc`=0x28 -> next cycle `id_valid`=0, `fq_count`=0, `hazDetect_PC`=1, and 0x28 never appears at ID.
5. Wrap-around: 10 instructions with alternating `id_stall` -> pointers wrap repeatedly, order is preserved, and `fq_count` never exceeds DEPTH.
6. Reset mid-operation: queue full, then `reset` pulsed 1 cycle -> next cycle all outputs are at reset values, and the post-reset instruction at 0x0 is delivered first.
